// File: rtl/flash_page_splitter.sv
// Splits erase/write/read commands into flash_drive ops that never cross a page boundary.
// Write data is staged one chunk at a time in a page buffer, then replayed as a gapless burst.
module flash_page_splitter #(
  parameter int unsigned P_PAGE_BYTES = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_cmd_type,
  input  logic [23:0] i_cmd_addr,
  input  logic [15:0] i_cmd_len,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  output logic        o_cmd_done,
  input  logic [7:0]  i_wr_data,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  output logic [1:0]  o_user_op_type,
  output logic [23:0] o_user_op_addr,
  output logic [8:0]  o_user_op_num,
  output logic        o_user_op_valid,
  input  logic        i_user_op_ready,
  output logic [7:0]  o_user_write_data,
  output logic        o_user_write_sop,
  output logic        o_user_write_eop,
  output logic        o_user_write_valid,
  input  logic        i_user_read_eop
);

  localparam logic [1:0] CmdErase = 2'd0;
  localparam logic [1:0] CmdWrite = 2'd1;
  localparam logic [1:0] CmdRead  = 2'd2;

  typedef enum logic [2:0] {StIdle, StFill, StIssue, StSend, StWaitRd} state_e;

  state_e      state_q;
  logic [1:0]  cmd_type_q;
  logic [23:0] cur_addr_q;
  logic [15:0] remaining_q;
  logic [8:0]  chunk_q;
  logic [8:0]  cnt_q;
  logic [7:0]  buf_q [P_PAGE_BYTES];

  logic        cmd_ready_q, cmd_done_q, wr_ready_q;
  logic [1:0]  op_type_q;
  logic [23:0] op_addr_q;
  logic [8:0]  op_num_q;
  logic        op_valid_q;
  logic [7:0]  wdata_q;
  logic        sop_q, eop_q, wvalid_q;

  logic [23:0] next_addr;
  logic [15:0] next_rem;
  logic [8:0]  next_chunk;
  logic        chunk_end;
  logic [7:0]  rd_byte;

  // Bytes left in the current page, capped by the bytes left in the command.
  function automatic logic [8:0] chunk_of(input logic [23:0] addr, input logic [15:0] rem);
    logic [8:0] space;
    space = 9'(P_PAGE_BYTES) - {1'b0, addr[7:0]};
    if (rem < {7'd0, space}) chunk_of = rem[8:0];
    else                     chunk_of = space;
  endfunction

  always_comb begin
    next_addr  = cur_addr_q + {15'd0, chunk_q};
    next_rem   = remaining_q - {7'd0, chunk_q};
    next_chunk = chunk_of(next_addr, next_rem);
    chunk_end  = (state_q == StSend && eop_q) || (state_q == StWaitRd && i_user_read_eop);
    rd_byte    = buf_q[cnt_q[7:0]];
  end

  always_ff @(posedge i_clk) begin
    if (state_q == StFill && wr_ready_q && i_wr_valid) begin
      buf_q[cnt_q[7:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cmd_type_q  <= CmdErase;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      chunk_q     <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      cmd_done_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      op_type_q   <= '0;
      op_addr_q   <= '0;
      op_num_q    <= '0;
      op_valid_q  <= 1'b0;
      wdata_q     <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      wvalid_q    <= 1'b0;
    end else begin
      cmd_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // Ready stays low during the done pulse so commands never overlap.
          if (!cmd_ready_q) begin
            cmd_ready_q <= 1'b1;
          end else if (i_cmd_valid) begin
            cmd_ready_q <= 1'b0;
            cmd_type_q  <= i_cmd_type;
            cur_addr_q  <= i_cmd_addr;
            remaining_q <= i_cmd_len;
            chunk_q     <= chunk_of(i_cmd_addr, i_cmd_len);
            cnt_q       <= '0;
            if (i_cmd_type == CmdErase) begin
              op_valid_q <= 1'b1;
              op_type_q  <= CmdErase;
              op_addr_q  <= i_cmd_addr;
              op_num_q   <= '0;
              state_q    <= StIssue;
            end else if (i_cmd_type == 2'd3 || i_cmd_len == 16'd0) begin
              cmd_done_q <= 1'b1;
            end else if (i_cmd_type == CmdWrite) begin
              wr_ready_q <= 1'b1;
              state_q    <= StFill;
            end else begin
              op_valid_q <= 1'b1;
              op_type_q  <= CmdRead;
              op_addr_q  <= i_cmd_addr;
              op_num_q   <= chunk_of(i_cmd_addr, i_cmd_len);
              state_q    <= StIssue;
            end
          end
        end
        StFill: begin
          if (i_wr_valid) begin
            if (cnt_q == chunk_q - 9'd1) begin
              wr_ready_q <= 1'b0;
              cnt_q      <= '0;
              op_valid_q <= 1'b1;
              op_type_q  <= CmdWrite;
              op_addr_q  <= cur_addr_q;
              op_num_q   <= chunk_q;
              state_q    <= StIssue;
            end else begin
              cnt_q <= cnt_q + 9'd1;
            end
          end
        end
        StIssue: begin
          if (i_user_op_ready) begin
            op_valid_q <= 1'b0;
            case (cmd_type_q)
              CmdErase: begin
                cmd_done_q <= 1'b1;
                state_q    <= StIdle;
              end
              CmdWrite: begin
                wvalid_q <= 1'b1;
                wdata_q  <= rd_byte;
                sop_q    <= 1'b1;
                eop_q    <= (chunk_q == 9'd1);
                cnt_q    <= 9'd1;
                state_q  <= StSend;
              end
              default: state_q <= StWaitRd;
            endcase
          end
        end
        StSend: begin
          if (eop_q) begin
            wvalid_q <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
          end else begin
            wdata_q <= rd_byte;
            sop_q   <= 1'b0;
            eop_q   <= (cnt_q == chunk_q - 9'd1);
            cnt_q   <= cnt_q + 9'd1;
          end
        end
        StWaitRd: ;
        default: state_q <= StIdle;
      endcase

      // Chunk bookkeeping overrides the per-state next state above.
      if (chunk_end) begin
        cur_addr_q  <= next_addr;
        remaining_q <= next_rem;
        chunk_q     <= next_chunk;
        cnt_q       <= '0;
        if (next_rem == 16'd0) begin
          cmd_done_q <= 1'b1;
          state_q    <= StIdle;
        end else if (cmd_type_q == CmdWrite) begin
          wr_ready_q <= 1'b1;
          state_q    <= StFill;
        end else begin
          op_valid_q <= 1'b1;
          op_type_q  <= CmdRead;
          op_addr_q  <= next_addr;
          op_num_q   <= next_chunk;
          state_q    <= StIssue;
        end
      end
    end
  end

  assign o_cmd_ready        = cmd_ready_q;
  assign o_cmd_done         = cmd_done_q;
  assign o_wr_ready         = wr_ready_q;
  assign o_user_op_type     = op_type_q;
  assign o_user_op_addr     = op_addr_q;
  assign o_user_op_num      = op_num_q;
  assign o_user_op_valid    = op_valid_q;
  assign o_user_write_data  = wdata_q;
  assign o_user_write_sop   = sop_q;
  assign o_user_write_eop   = eop_q;
  assign o_user_write_valid = wvalid_q;

endmodule

// File: tb/tb_flash_page_splitter.sv
// Directed bench for flash_page_splitter: op splitting, write bursts, read pacing, erase, reset.
module tb_flash_page_splitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cmd_type = '0;
  logic [23:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready, cmd_done;
  logic [7:0]  wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [1:0]  op_type;
  logic [23:0] op_addr;
  logic [8:0]  op_num;
  logic        op_valid;
  logic        op_ready = 1'b1;
  logic [7:0]  w_data;
  logic        w_sop, w_eop, w_valid;
  logic        rd_eop = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [1:0]  m_type [$];
  logic [23:0] m_addr [$];
  logic [8:0]  m_num  [$];
  int          m_cyc  [$];
  logic [7:0]  b_data [$];
  logic        b_sop  [$];
  logic        b_eop  [$];
  int          b_cyc  [$];
  int          eop_cyc [$];

  flash_page_splitter #(.P_PAGE_BYTES(256)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_type(cmd_type), .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .o_cmd_done(cmd_done),
    .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .o_user_op_type(op_type), .o_user_op_addr(op_addr), .o_user_op_num(op_num),
    .o_user_op_valid(op_valid), .i_user_op_ready(op_ready),
    .o_user_write_data(w_data), .o_user_write_sop(w_sop), .o_user_write_eop(w_eop),
    .o_user_write_valid(w_valid), .i_user_read_eop(rd_eop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (op_valid && op_ready) begin
      m_type.push_back(op_type); m_addr.push_back(op_addr);
      m_num.push_back(op_num);   m_cyc.push_back(cyc);
    end
    if (w_valid) begin
      b_data.push_back(w_data); b_sop.push_back(w_sop);
      b_eop.push_back(w_eop);   b_cyc.push_back(cyc);
    end
    if (cmd_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    m_type.delete(); m_addr.delete(); m_num.delete(); m_cyc.delete();
    b_data.delete(); b_sop.delete(); b_eop.delete(); b_cyc.delete(); eop_cyc.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [23:0] a, input logic [15:0] l);
    int g = 0;
    while (!cmd_ready && g < 200) begin tick(); g++; end
    check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    cmd_type = t; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int n, input logic [7:0] base);
    int i = 0;
    int g = 0;
    while (i < n && g < 3000) begin
      if (wr_ready) begin
        wr_valid = 1'b1; wr_data = base + 8'(i); i++;
      end else begin
        wr_valid = 1'b0;
      end
      tick(); g++;
    end
    wr_valid = 1'b0;
    check("feed_count", i, n);
  endtask

  task automatic wait_done(input int start, input string tag);
    int g = 0;
    while (done_cnt == start && g < 3000) begin tick(); g++; end
    tick(); tick();
    check(tag, done_cnt - start, 1);
  endtask

  task automatic check_op(input int k, input logic [1:0] t, input logic [23:0] a,
                          input logic [8:0] n);
    if (k < m_type.size()) begin
      check("op_type", m_type[k], t);
      check("op_addr", m_addr[k], a);
      check("op_num", m_num[k], n);
    end else begin
      check("op_missing", k, m_type.size());
    end
  endtask

  // Verifies one burst: data, sop only at start, eop only at end, gapless, after its op.
  task automatic check_burst(input int first, input int len, input logic [7:0] base, input int op_k);
    int bad = 0;
    if (first + len > b_data.size() || op_k >= m_cyc.size()) begin
      check("burst_short", b_data.size(), first + len);
    end else begin
      for (int i = 0; i < len; i++) begin
        if (b_data[first+i] !== base + 8'(i)) bad++;
        if (b_sop[first+i] !== (i == 0)) bad++;
        if (b_eop[first+i] !== (i == len - 1)) bad++;
        if (b_cyc[first+i] != m_cyc[op_k] + 1 + i) bad++;
      end
      check("burst_shape", bad, 0);
    end
  endtask

  initial begin
    int d0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_outputs", {28'd0, cmd_done, wr_ready, op_valid, w_valid}, 32'd0);

    // Write crossing a page boundary.
    clear_logs(); d0 = done_cnt;
    fork
      send_cmd(2'd1, 24'h0000F0, 16'd40);
      begin tick(); feed(40, 8'hA0); end
    join
    wait_done(d0, "t1_done");
    check("t1_ops", m_type.size(), 2);
    check_op(0, 2'd1, 24'h0000F0, 9'd16);
    check_op(1, 2'd1, 24'h000100, 9'd24);
    check("t1_bytes", b_data.size(), 40);
    check_burst(0, 16, 8'hA0, 0);
    check_burst(16, 24, 8'hB0, 1);

    // Stray read eop while idle must do nothing.
    d0 = done_cnt; clear_logs();
    rd_eop = 1'b1; tick(); rd_eop = 1'b0; repeat (3) tick();
    check("stray_eop", done_cnt - d0 + m_type.size(), 0);

    // Read of 600 bytes: next op only after the previous chunk's eop.
    clear_logs(); d0 = done_cnt;
    fork
      send_cmd(2'd2, 24'h000000, 16'd600);
      for (int k = 0; k < 3; k++) begin
        int g = 0;
        while (m_cyc.size() <= k && g < 500) begin tick(); g++; end
        repeat (4) tick();
        rd_eop = 1'b1; eop_cyc.push_back(cyc); tick(); rd_eop = 1'b0;
      end
    join
    wait_done(d0, "t2_done");
    check("t2_ops", m_type.size(), 3);
    check_op(0, 2'd2, 24'h000000, 9'd256);
    check_op(1, 2'd2, 24'h000100, 9'd256);
    check_op(2, 2'd2, 24'h000200, 9'd88);
    if (m_cyc.size() == 3) begin
      check("t2_pace1", {31'd0, m_cyc[1] > eop_cyc[0]}, 32'd1);
      check("t2_pace2", {31'd0, m_cyc[2] > eop_cyc[1]}, 32'd1);
    end

    // Erase with op_ready held low for 5 cycles.
    clear_logs(); d0 = done_cnt;
    op_ready = 1'b0;
    send_cmd(2'd0, 24'h010000, 16'd77);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) op_ready = 1'b1;
      check("t3_valid", {31'd0, op_valid}, 32'd1);
      check("t3_stable", {op_type, op_num, op_addr}, {2'd0, 9'd0, 24'h010000});
      tick();
    end
    check("t3_drop", {30'd0, op_valid, cmd_done}, 32'd1);
    check("t3_ready_low", {31'd0, cmd_ready}, 32'd0);
    tick();
    check("t3_after", {30'd0, cmd_ready, cmd_done}, 32'd2);
    check("t3_done_cnt", done_cnt - d0, 1);

    // Write at the top of the address space wraps to zero.
    clear_logs(); d0 = done_cnt;
    fork
      send_cmd(2'd1, 24'hFFFFFF, 16'd2);
      begin tick(); feed(2, 8'h5A); end
    join
    wait_done(d0, "t4_done");
    check("t4_ops", m_type.size(), 2);
    check_op(0, 2'd1, 24'hFFFFFF, 9'd1);
    check_op(1, 2'd1, 24'h000000, 9'd1);
    check_burst(0, 1, 8'h5A, 0);
    check_burst(1, 1, 8'h5B, 1);

    // Zero-length read: done the cycle after acceptance, no op.
    clear_logs(); d0 = done_cnt;
    send_cmd(2'd2, 24'h001234, 16'd0);
    check("t5_done", {30'd0, cmd_done, cmd_ready}, 32'd2);
    tick(); tick();
    check("t5_no_op", m_type.size(), 0);

    // Reset in the middle of a write burst, then a clean write.
    clear_logs(); d0 = done_cnt;
    fork
      send_cmd(2'd1, 24'h000000, 16'd8);
      begin tick(); feed(8, 8'h10); end
    join
    begin
      int g = 0;
      while (!w_valid && g < 100) begin tick(); g++; end
      check("t6_burst_seen", {31'd0, w_valid}, 32'd1);
    end
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_rst_out", {29'd0, w_valid, op_valid, wr_ready}, 32'd0);
    check("t6_rst_ready", {30'd0, cmd_ready, cmd_done}, 32'd2);
    repeat (4) tick();
    check("t6_no_done", done_cnt - d0, 0);
    clear_logs(); d0 = done_cnt;
    fork
      send_cmd(2'd1, 24'h000020, 16'd3);
      begin tick(); feed(3, 8'hC0); end
    join
    wait_done(d0, "t6_done");
    check("t6_ops", m_type.size(), 1);
    check_op(0, 2'd1, 24'h000020, 9'd3);
    check_burst(0, 3, 8'hC0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
